// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard inputs and per-register enable/flush controls.
// The master modport drives the hazard inputs; the slave modport is the sequencer itself.
interface pipe_hazard_ctrl_if;
  logic       memread_ex;
  logic [4:0] rt_ex;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic       jump_id;
  logic       branch_taken_mem;
  logic       mem_req;
  logic       mem_ready;

  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_en;
  logic       id_ex_flush;
  logic       ex_mem_en;
  logic       ex_mem_flush;
  logic       mem_wb_bubble;
  logic       stall;
  logic       err;

  modport slave (
    input  memread_ex, rt_ex, rs_id, rt_id, jump_id, branch_taken_mem, mem_req, mem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
           mem_wb_bubble, stall, err
  );

  modport master (
    output memread_ex, rt_ex, rs_id, rt_id, jump_id, branch_taken_mem, mem_req, mem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
           mem_wb_bubble, stall, err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage MIPS pipeline with a memory-wait timeout FSM.
// Optional event counters are built when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  pipe_hazard_ctrl_if.slave       hz
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]             perf_mem_stall,
  output logic [31:0]             perf_loaduse,
  output logic [31:0]             perf_flush
`endif
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {StRun, StWait, StError} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;

  logic             mem_stall;
  logic             load_use;
  logic             live;
  logic             act_mem;
  logic             act_branch;
  logic             act_loaduse;
  logic             act_jump;
  logic [CNT_W-1:0] cnt_inc;

  // Raw hazard conditions, before priority resolution.
  assign mem_stall = hz.mem_req & ~hz.mem_ready;
  assign load_use  = hz.memread_ex & (hz.rt_ex != 5'd0) &
                     ((hz.rt_ex == hz.rs_id) | (hz.rt_ex == hz.rt_id));

  // Outputs are forced idle while reset is held, even between clock edges.
  assign live        = rst_n & (state_q != StError);
  assign act_mem     = live & mem_stall;
  assign act_branch  = live & ~mem_stall & hz.branch_taken_mem;
  assign act_loaduse = live & ~mem_stall & ~hz.branch_taken_mem & load_use;
  assign act_jump    = live & ~mem_stall & ~hz.branch_taken_mem & ~load_use & hz.jump_id;

  assign cnt_inc = (wait_cnt_q == CntMax) ? CntMax : wait_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StWait;
          wait_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          wait_cnt_d = '0;
        end
      end
      StWait: begin
        // A completion on the timeout cycle wins over the timeout.
        if (!mem_stall) begin
          state_d    = StRun;
          wait_cnt_d = '0;
        end else if (cnt_inc >= TimeoutCnt) begin
          state_d    = StError;
          wait_cnt_d = cnt_inc;
          err_d      = 1'b1;
        end else begin
          wait_cnt_d = cnt_inc;
        end
      end
      StError: begin
        err_d = 1'b1;
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    hz.pc_en         = 1'b0;
    hz.if_id_en      = 1'b0;
    hz.if_id_flush   = 1'b0;
    hz.id_ex_en      = 1'b0;
    hz.id_ex_flush   = 1'b0;
    hz.ex_mem_en     = 1'b0;
    hz.ex_mem_flush  = 1'b0;
    hz.mem_wb_bubble = 1'b0;
    hz.stall         = 1'b0;
    hz.err           = err_q;
    if (rst_n && state_q == StError) begin
      hz.mem_wb_bubble = 1'b1;
      hz.stall         = 1'b1;
    end else if (live) begin
      hz.pc_en     = ~(act_mem | act_loaduse);
      hz.if_id_en  = ~(act_mem | act_loaduse);
      hz.id_ex_en  = ~act_mem;
      hz.ex_mem_en = ~act_mem;
      // EX/MEM holds during a memory wait, so the bubble keeps WB from committing twice.
      hz.mem_wb_bubble = act_mem;
      hz.stall         = act_mem | act_loaduse;
      hz.if_id_flush   = act_branch | act_jump;
      hz.id_ex_flush   = act_branch | act_loaduse;
      hz.ex_mem_flush  = act_branch;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_mem_stall_q, perf_loaduse_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_mem_stall_q <= '0;
      perf_loaduse_q   <= '0;
      perf_flush_q     <= '0;
    end else begin
      if (act_mem && perf_mem_stall_q != 32'hFFFF_FFFF) begin
        perf_mem_stall_q <= perf_mem_stall_q + 32'd1;
      end
      if (act_loaduse && perf_loaduse_q != 32'hFFFF_FFFF) begin
        perf_loaduse_q <= perf_loaduse_q + 32'd1;
      end
      if (act_branch && perf_flush_q != 32'hFFFF_FFFF) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  assign perf_mem_stall = perf_mem_stall_q;
  assign perf_loaduse   = perf_loaduse_q;
  assign perf_flush     = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a rule-level model checked every cycle plus literal pins.
module tb_pipe_hazard_ctrl;
  localparam int MemTo = 16;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  pipe_hazard_ctrl_if hz ();

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_mem_stall, perf_loaduse, perf_flush;
`endif

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT (MemTo),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_mem_stall (perf_mem_stall),
    .perf_loaduse   (perf_loaduse),
    .perf_flush     (perf_flush)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state: length of the current memory wait and the sticky error flag.
  int m_wait;
  bit m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 0;
      m_err  <= 1'b0;
    end else if (!m_err) begin
      if (hz.mem_req && !hz.mem_ready) begin
        m_wait <= m_wait + 1;
        if (m_wait + 1 >= MemTo) m_err <= 1'b1;
      end else begin
        m_wait <= 0;
      end
    end
  end

  // Bit order: pc_en if_id_en if_id_flush id_ex_en id_ex_flush ex_mem_en ex_mem_flush
  //            mem_wb_bubble stall err
  function automatic logic [9:0] expect_out();
    logic lu;
    if (!rst_n)                       return 10'b0000000000;
    if (m_err)                        return 10'b0000000111;
    if (hz.mem_req && !hz.mem_ready)  return 10'b0000000110;
    if (hz.branch_taken_mem)          return 10'b1111111000;
    lu = hz.memread_ex && hz.rt_ex != 0 && (hz.rt_ex == hz.rs_id || hz.rt_ex == hz.rt_id);
    if (lu)                           return 10'b0001110010;
    if (hz.jump_id)                   return 10'b1111010000;
    return 10'b1101010000;
  endfunction

  function automatic logic [9:0] dut_out();
    return {hz.pc_en, hz.if_id_en, hz.if_id_flush, hz.id_ex_en, hz.id_ex_flush,
            hz.ex_mem_en, hz.ex_mem_flush, hz.mem_wb_bubble, hz.stall, hz.err};
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    logic [9:0] e;
    logic [9:0] a;
    e = expect_out();
    a = dut_out();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL cycle_outputs: got %b want %b at %0t", a, e, $time);
    end
  endtask

  // Compare at each negedge, then advance to just past the next rising edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmp_cycle();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_inputs();
    hz.memread_ex       = 1'b0;
    hz.rt_ex            = 5'd0;
    hz.rs_id            = 5'd0;
    hz.rt_id            = 5'd0;
    hz.jump_id          = 1'b0;
    hz.branch_taken_mem = 1'b0;
    hz.mem_req          = 1'b0;
    hz.mem_ready        = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle_inputs();
    #3;
    check("reset_pc_en", hz.pc_en, 1'b0);
    check("reset_stall", hz.stall, 1'b0);
    check("reset_err", hz.err, 1'b0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(2);
    check("run_pc_en", hz.pc_en, 1'b1);

    // Load-use: one stalled cycle, then rt_ex=0 never stalls.
    hz.memread_ex = 1'b1; hz.rt_ex = 5'd5; hz.rs_id = 5'd5; hz.rt_id = 5'd9;
    #1;
    check("lu_pc_en", hz.pc_en, 1'b0);
    check("lu_if_id_en", hz.if_id_en, 1'b0);
    check("lu_id_ex_flush", hz.id_ex_flush, 1'b1);
    step(1);
    hz.memread_ex = 1'b0;
    #1;
    check("lu_after_pc_en", hz.pc_en, 1'b1);
    step(1);
    hz.memread_ex = 1'b1; hz.rt_ex = 5'd0; hz.rs_id = 5'd0;
    #1;
    check("lu_r0_stall", hz.stall, 1'b0);
    step(1);
    hz.rt_ex = 5'd7; hz.rt_id = 5'd7; hz.rs_id = 5'd1;
    step(1);

    // Branch overrides a concurrent load-use.
    hz.branch_taken_mem = 1'b1; hz.rt_ex = 5'd3; hz.rs_id = 5'd3;
    #1;
    check("br_if_id_flush", hz.if_id_flush, 1'b1);
    check("br_ex_mem_flush", hz.ex_mem_flush, 1'b1);
    check("br_pc_en", hz.pc_en, 1'b1);
    step(1);
    idle_inputs();
    hz.jump_id = 1'b1;
    #1;
    check("jmp_if_id_flush", hz.if_id_flush, 1'b1);
    check("jmp_id_ex_flush", hz.id_ex_flush, 1'b0);
    step(1);

    // Memory wait of 4 cycles, then completion; branch is ignored while waiting.
    idle_inputs();
    hz.mem_req = 1'b1; hz.branch_taken_mem = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("mw_pc_en", hz.pc_en, 1'b0);
      check("mw_bubble", hz.mem_wb_bubble, 1'b1);
      step(1);
    end
    hz.mem_ready = 1'b1; hz.branch_taken_mem = 1'b0;
    #1;
    check("mw_done_ex_mem_en", hz.ex_mem_en, 1'b1);
    step(1);
    idle_inputs();
    step(1);

    // Asynchronous reset in the middle of a wait.
    hz.mem_req = 1'b1;
    step(3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc_en", hz.pc_en, 1'b0);
    check("arst_bubble", hz.mem_wb_bubble, 1'b0);
    step(1);
    rst_n = 1'b1; hz.mem_req = 1'b0;
    #1;
    check("arst_release_pc_en", hz.pc_en, 1'b1);
    step(1);

    // Completion on the cycle the count would reach the timeout.
    hz.mem_req = 1'b1;
    step(MemTo - 1);
    check("bnd_pre_err", hz.err, 1'b0);
    hz.mem_ready = 1'b1;
    step(1);
    check("bnd_err", hz.err, 1'b0);
    hz.mem_ready = 1'b0;
    step(MemTo - 1);
    check("bnd_recount_err", hz.err, 1'b0);
    hz.mem_req = 1'b0;
    step(1);

    // Timeout and sticky error.
    hz.mem_req = 1'b1;
    step(MemTo - 1);
    check("to_15_err", hz.err, 1'b0);
    step(1);
    check("to_16_err", hz.err, 1'b1);
    check("to_pc_en", hz.pc_en, 1'b0);
    hz.mem_req = 1'b0; hz.jump_id = 1'b1;
    step(3);
    check("to_sticky_err", hz.err, 1'b1);
    check("to_sticky_stall", hz.stall, 1'b1);
    hz.jump_id = 1'b0;
    rst_n = 1'b0;
    #1;
    check("to_reset_err", hz.err, 1'b0);
    step(1);
    rst_n = 1'b1;
    #1;
    check("to_after_pc_en", hz.pc_en, 1'b1);
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
